lcd_gfx_frame_ctrl: RTL
=======================

Name: lcd_gfx_frame_ctrl

Overview:
Parametrised ST7920-class 128x64 graphic LCD controller; next generation of the single-shot block display controller. Streams a frame buffer from a synchronous ROM/RAM to the LCD over the 8-bit parallel bus on request, with a start/busy/done handshake. The power-up init sequence runs once only. A clear mode writes zeros without reading memory. Sits between the frame memory and the LCD pins.

Parameters:
CLK_DIV, 2500, clk cycles per bus half-step (50 us at 50 MHz); must be >= RD_LAT+2
ROWS, 64, pixel rows; multiple of 32, max 64
COL_BYTES, 16, bytes per row; even, max 16
ADDR_W, 10, frame memory address width; must be >= clog2(ROWS*COL_BYTES)
RD_LAT, 1, frame memory read latency in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  frame request; sampled when busy=0
mode  in  1  0 = copy frame memory, 1 = clear (write 0x00); captured with start
busy  out  1  high from accepted start until done
done  out  1  one-clk pulse at end of frame
mem_addr  out  ADDR_W  frame memory byte address = row*COL_BYTES + col
mem_data  in  8  frame memory read data, valid RD_LAT clks after mem_addr
rs  out  1  0 = command, 1 = data
rw  out  1  tied 0
en  out  1  LCD enable; LCD latches on falling edge
data  out  8  LCD bus

Behaviour:
- Reset: busy=0, done=0, en=0, rs=0, data=0x00, mem_addr=0, state IDLE, init_done=0, divider=0.
- Step timing: one bus step = 2*CLK_DIV clk cycles. rs/data change only at step start. en=0 in the first half, en=1 in the second half, so the falling edge lands at step end. en is never high outside an active step.
- States and bytes, one step each:
  - IDLE: en=0. On start && !busy, capture mode, set busy=1, start the divider, and go to INIT0 if init_done=0, else SETY.
  - INIT0: 0x30. ENTRY: 0x06. DISP: 0x0C. INIT1: 0x36. After INIT1, set init_done=1 and go to SETY.
  - SETY: rs=0, data=0x80|row[4:0].
  - SETX: rs=0, data=0x80|(row>=32 ? 0x08 : 0)|0.
  - WRITE: rs=1, one byte per step. After the last byte of the row (col=COL_BYTES-1): go to SETY if row<ROWS-1, else to FIN.
  - FIN: no bus step. Pulse done for 1 clk, clear busy, return to IDLE.
- Row/col counters: col runs 0..COL_BYTES-1, row runs 0..ROWS-1. Both clear on start.
- Memory read: mem_addr is updated at the start of the step preceding each WRITE step. The WRITE step drives the data latched from mem_data. mem_addr is held otherwise.
- Clear mode: WRITE data=0x00 and mem_addr holds 0.
- Frame length:
  - Without init: ROWS*(2+COL_BYTES) steps (1152 with defaults).
  - With init: 4 more steps.
- start while busy is ignored; no queuing.
- Reset mid-frame: all outputs return to reset values immediately (en drops asynchronously) and init_done=0, so the next start re-runs init.
- start and done can never coincide, because done is issued from FIN only.

Test Plan:
1. CLK_DIV=4, ROWS=64, COL_BYTES=16, memory[i]=i[7:0]; release rst, pulse start, mode=0.
   - First four en falling edges carry rs=0 data 0x30, 0x06, 0x0C, 0x36, then SETY 0x80, SETX 0x80, then rs=1 data 0x00..0x0F.
   - busy high for 1156*8 clks; one done pulse.
2. Same setup, second start after done: the first command is SETY 0x80 (no init); frame length is 1152 steps.
3. Row 32: SETY=0x80, SETX=0x88, first data byte = mem[512][7:0] = 0x00. Row 33: SETY=0x81, first byte = mem[528] = 0x10.
4. start with mode=1: every rs=1 byte is 0x00; mem_addr stays 0 throughout.
5. Assert rst at step 300 of the frame:
   - en/busy drop the same cycle, and done never pulses.
   - The next start emits 0x30 first.
6. Pulse start repeatedly while busy=1: no restart, and exactly one done per accepted start. Also check en=0 during the first CLK_DIV clks of every step.

Source files
------------

// File: rtl/lcd_gfx_frame_ctrl.sv
// ST7920-class graphic LCD frame streamer: one-time init, then per-row SETY/SETX
// addressing followed by COL_BYTES data writes read from a synchronous frame memory.
module lcd_gfx_frame_ctrl #(
    parameter int CLK_DIV   = 2500,
    parameter int ROWS      = 64,
    parameter int COL_BYTES = 16,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              rs,
    output logic              rw,
    output logic              en,
    output logic [7:0]        data
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = (COL_BYTES > 1) ? $clog2(COL_BYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT0, S_ENTRY, S_DISP, S_INIT1, S_SETY, S_SETX, S_WRITE, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              mode_q, mode_d;
    logic              init_done_q, init_done_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              rs_q, rs_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        pix_q, pix_d;
    logic              step_end;
    logic              new_step;
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] row_base;

    assign step_end = (div_q == DIV_W'(2 * CLK_DIV - 1));
    assign last_col = (col_q == COL_W'(COL_BYTES - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    assign row_base = ADDR_W'(row_d) * ADDR_W'(COL_BYTES);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        row_d       = row_q;
        col_d       = col_q;
        mode_d      = mode_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rs_d        = rs_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        pix_d       = pix_q;
        new_step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    mode_d     = mode;
                    busy_d     = 1'b1;
                    row_d      = '0;
                    col_d      = '0;
                    div_d      = '0;
                    mem_addr_d = '0;
                    new_step   = 1'b1;
                    state_d    = init_done_q ? S_SETY : S_INIT0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                div_d = step_end ? '0 : div_q + DIV_W'(1);
                if (step_end) begin
                    new_step = 1'b1;
                    case (state_q)
                        S_INIT0: state_d = S_ENTRY;
                        S_ENTRY: state_d = S_DISP;
                        S_DISP:  state_d = S_INIT1;
                        S_INIT1: begin
                            init_done_d = 1'b1;
                            state_d     = S_SETY;
                        end
                        S_SETY:  state_d = S_SETX;
                        S_SETX: begin
                            col_d   = '0;
                            state_d = S_WRITE;
                        end
                        S_WRITE: begin
                            if (last_col) begin
                                col_d = '0;
                                if (last_row) begin
                                    new_step = 1'b0;
                                    state_d  = S_FIN;
                                end else begin
                                    row_d   = row_q + ROW_W'(1);
                                    state_d = S_SETY;
                                end
                            end else begin
                                col_d   = col_q + COL_W'(1);
                                state_d = S_WRITE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        // The frame is over the moment FIN is entered; done rides the single FIN cycle.
        if (state_d == S_FIN) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (new_step) begin
            case (state_d)
                S_INIT0: begin rs_d = 1'b0; data_d = 8'h30; end
                S_ENTRY: begin rs_d = 1'b0; data_d = 8'h06; end
                S_DISP:  begin rs_d = 1'b0; data_d = 8'h0C; end
                S_INIT1: begin rs_d = 1'b0; data_d = 8'h36; end
                S_SETY:  begin rs_d = 1'b0; data_d = {3'b100, row_d[4:0]}; end
                S_SETX: begin
                    rs_d   = 1'b0;
                    data_d = (32'(row_d) >= 32) ? 8'h88 : 8'h80;
                    if (!mode_d) mem_addr_d = row_base;
                end
                S_WRITE: begin
                    rs_d   = 1'b1;
                    data_d = mode_d ? 8'h00 : pix_q;
                    if (!mode_d && (col_d != COL_W'(COL_BYTES - 1)))
                        mem_addr_d = row_base + ADDR_W'(col_d) + ADDR_W'(1);
                end
                default: ;
            endcase
        end

        // Memory data for the next WRITE is valid RD_LAT clocks after the address moved.
        if (busy_q && (div_q == DIV_W'(RD_LAT)))
            pix_d = mem_data;

        en_d = (state_d != S_IDLE) && (state_d != S_FIN) && (div_d >= DIV_W'(CLK_DIV));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mode_q      <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            mem_addr_q  <= '0;
            pix_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            pix_q       <= pix_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign en       = en_q;
    assign rs       = rs_q;
    assign rw       = 1'b0;
    assign data     = data_q;
    assign mem_addr = mem_addr_q;

endmodule
